// File: rtl/stream_demux.sv
// 1-to-N_OUT stream demux with a one-entry holding register per channel; 1-cycle latency.
// in_ready drops only when the selected channel is full and not draining; bad selects are dropped.
module stream_demux #(
   parameter int DATA_W = 8,
   parameter int N_OUT  = 4,
   parameter int SEL_W  = 3,
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [SEL_W-1:0]        in_sel,
   output logic [N_OUT-1:0]        out_valid,
   input  logic [N_OUT-1:0]        out_ready,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]        drop_cnt,
   output logic                    sel_err
);
   localparam logic [SEL_W:0] NOUT_C = (SEL_W+1)'(N_OUT);

   logic [N_OUT-1:0]             vld_q, vld_d;
   logic [N_OUT-1:0]             sel_hit, drain;
   logic [N_OUT-1:0][DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         err_q, err_d;
   logic                         sel_ok, accept, drop;

   // One-hot decode avoids indexing the channel vectors with an out-of-range select.
   always_comb begin
      sel_hit = '0;
      for (int k = 0; k < N_OUT; k++) begin
         sel_hit[k] = (in_sel == SEL_W'(k));
      end
   end

   assign sel_ok   = ({1'b0, in_sel} < NOUT_C);
   assign drain    = vld_q & out_ready;
   assign in_ready = ~sel_ok | (|(sel_hit & (~vld_q | out_ready)));
   assign accept   = in_valid & in_ready;
   assign drop     = accept & ~sel_ok;

   // Load wins over drain, so a full channel can be refilled in the cycle it empties.
   always_comb begin
      vld_d  = vld_q & ~drain;
      data_d = data_q;
      for (int k = 0; k < N_OUT; k++) begin
         if (accept && sel_hit[k]) begin
            vld_d[k]  = 1'b1;
            data_d[k] = in_data;
         end
      end
   end

   assign cnt_d = (drop && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
   assign err_d = drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         data_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign out_valid = vld_q;
   assign out_data  = data_q;
   assign drop_cnt  = cnt_q;
   assign sel_err   = err_q;
endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed vector table, hand-written stall/reset/saturation
// sequences, and a randomised run scored against per-channel pending queues.
module tb_stream_demux;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic [2:0]  in_sel = '0;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready = '0;
   logic [31:0] out_data;
   logic [7:0]  drop_cnt;
   logic        sel_err;

   int n_chk = 0;
   int n_err = 0;

   stream_demux #(.DATA_W(8), .N_OUT(4), .SEL_W(3), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .drop_cnt(drop_cnt), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [2:0] sel;
      logic [7:0] dat;
      logic [3:0] ordy;
      logic       rdy;
      logic [3:0] ovld;
      logic       err;
      logic [7:0] cnt;
      int         ch;
      logic [7:0] chd;
   } vec_t;

   vec_t vecs[$];

   // Reference model state for the randomised run
   logic [7:0] pend[4][$];
   int         m_cnt, n_sent, n_recv, n_beats;
   logic       m_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] d, input logic [3:0] r);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = '0;
      rst       = 1'b1;
      #3;
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   function automatic logic [7:0] ch_dat(input int k);
      logic [31:0] v;
      v = out_data;
      return v[k*8 +: 8];
   endfunction

   task automatic model_step();
      logic er;
      logic acc;
      er = (in_sel >= 3'd4) || (pend[in_sel].size() == 0) || out_ready[in_sel];
      chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, er});
      chk("rnd_sel_err", {31'b0, sel_err}, {31'b0, m_err});
      chk("rnd_drop_cnt", {24'b0, drop_cnt}, m_cnt);
      for (int k = 0; k < 4; k++) begin
         chk("rnd_out_valid", {31'b0, out_valid[k]}, {31'b0, pend[k].size() != 0});
         if (pend[k].size() != 0) chk("rnd_out_data", {24'b0, ch_dat(k)}, {24'b0, pend[k][0]});
      end
      for (int k = 0; k < 4; k++) begin
         if (pend[k].size() != 0 && out_ready[k]) begin
            void'(pend[k].pop_front());
            n_recv++;
         end
      end
      acc   = in_valid && er;
      m_err = acc && (in_sel >= 3'd4);
      if (acc) begin
         n_beats++;
         if (in_sel < 3'd4) begin
            pend[in_sel].push_back(in_data);
            n_sent++;
         end else if (m_cnt != 255) begin
            m_cnt++;
         end
      end
   endtask

   initial begin
      // Directed vectors, applied back-to-back from a clean reset
      vecs.push_back('{1'b1, 3'd2, 8'hA5, 4'hF, 1'b1, 4'b0100, 1'b0, 8'd0, 2, 8'hA5});
      vecs.push_back('{1'b1, 3'd0, 8'h11, 4'hF, 1'b1, 4'b0001, 1'b0, 8'd0, 0, 8'h11});
      vecs.push_back('{1'b1, 3'd1, 8'h22, 4'hF, 1'b1, 4'b0010, 1'b0, 8'd0, 1, 8'h22});
      vecs.push_back('{1'b1, 3'd2, 8'h33, 4'hF, 1'b1, 4'b0100, 1'b0, 8'd0, 2, 8'h33});
      vecs.push_back('{1'b1, 3'd3, 8'h44, 4'hF, 1'b1, 4'b1000, 1'b0, 8'd0, 3, 8'h44});
      vecs.push_back('{1'b1, 3'd5, 8'hFF, 4'h0, 1'b1, 4'b1000, 1'b1, 8'd1, 3, 8'h44});
      vecs.push_back('{1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'b1000, 1'b0, 8'd1, 3, 8'h44});
      vecs.push_back('{1'b1, 3'd3, 8'h55, 4'h0, 1'b0, 4'b1000, 1'b0, 8'd1, 3, 8'h44});
      vecs.push_back('{1'b1, 3'd3, 8'h55, 4'h8, 1'b1, 4'b1000, 1'b0, 8'd1, 3, 8'h55});
      vecs.push_back('{1'b0, 3'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 1'b0, 8'd1, 3, 8'h55});
      vecs.push_back('{1'b1, 3'd7, 8'h00, 4'hF, 1'b1, 4'b0000, 1'b1, 8'd2, 3, 8'h55});
      vecs.push_back('{1'b1, 3'd4, 8'h00, 4'hF, 1'b1, 4'b0000, 1'b1, 8'd3, 3, 8'h55});
      vecs.push_back('{1'b0, 3'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 1'b0, 8'd3, 0, 8'h11});

      #12;
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_drop_cnt", {24'b0, drop_cnt}, 32'h0);
      chk("rst_sel_err", {31'b0, sel_err}, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].vld, vecs[i].sel, vecs[i].dat, vecs[i].ordy);
         chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].rdy});
         tick();
         chk($sformatf("vec%0d_out_valid", i), {28'b0, out_valid}, {28'b0, vecs[i].ovld});
         chk($sformatf("vec%0d_sel_err", i), {31'b0, sel_err}, {31'b0, vecs[i].err});
         chk($sformatf("vec%0d_drop_cnt", i), {24'b0, drop_cnt}, {24'b0, vecs[i].cnt});
         chk($sformatf("vec%0d_ch_data", i), {24'b0, ch_dat(vecs[i].ch)}, {24'b0, vecs[i].chd});
      end

      // Channel 1 stalls: head-of-line block on ch1, ch3 still passes, then load-on-drain
      drive(1'b1, 3'd1, 8'hB1, 4'b1101);
      chk("stall_first_rdy", {31'b0, in_ready}, 32'h1);
      tick();
      chk("stall_first_vld", {28'b0, out_valid}, 32'b0010);
      drive(1'b1, 3'd1, 8'hB2, 4'b1101);
      chk("stall_second_rdy", {31'b0, in_ready}, 32'h0);
      tick();
      chk("stall_hold_data", {24'b0, ch_dat(1)}, 32'hB1);
      drive(1'b1, 3'd3, 8'hC3, 4'b1101);
      chk("stall_other_rdy", {31'b0, in_ready}, 32'h1);
      tick();
      chk("stall_other_vld", {28'b0, out_valid}, 32'b1010);
      chk("stall_hold_data2", {24'b0, ch_dat(1)}, 32'hB1);
      chk("stall_other_data", {24'b0, ch_dat(3)}, 32'hC3);
      drive(1'b1, 3'd1, 8'hB2, 4'b0111);
      chk("release_rdy", {31'b0, in_ready}, 32'h1);
      tick();
      chk("release_vld", {28'b0, out_valid}, 32'b1010);
      chk("release_data", {24'b0, ch_dat(1)}, 32'hB2);

      // Asynchronous reset away from the clock edge while out_valid=1010
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", {28'b0, out_valid}, 32'h0);
      chk("arst_drop_cnt", {24'b0, drop_cnt}, 32'h0);
      chk("arst_out_data", out_data, 32'h0);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      drive(1'b1, 3'd0, 8'h5A, 4'h0);
      chk("post_rst_rdy", {31'b0, in_ready}, 32'h1);
      tick();
      chk("post_rst_vld", {28'b0, out_valid}, 32'b0001);
      chk("post_rst_data", {24'b0, ch_dat(0)}, 32'h5A);

      // Drop counter saturation
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 3'd6, 8'hFF, 4'hF);
         tick();
         if (i == 99) chk("drop_cnt_100", {24'b0, drop_cnt}, 32'd100);
      end
      chk("drop_cnt_sat", {24'b0, drop_cnt}, 32'd255);
      chk("drop_sel_err", {31'b0, sel_err}, 32'h1);
      chk("drop_no_vld", {28'b0, out_valid}, 32'h0);
      drive(1'b0, 3'd0, 8'h00, 4'hF);
      tick();
      chk("drop_err_clear", {31'b0, sel_err}, 32'h0);
      chk("drop_cnt_hold", {24'b0, drop_cnt}, 32'd255);

      // Randomised traffic against the queue model
      do_reset();
      m_cnt = 0; m_err = 1'b0; n_sent = 0; n_recv = 0; n_beats = 0;
      begin
         int cyc;
         cyc = 0;
         while (n_beats < 2000 && cyc < 20000) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 5)), 8'($urandom), 4'($urandom));
            model_step();
            tick();
            cyc++;
         end
         chk("rnd_budget", {31'b0, cyc >= 20000}, 32'h0);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 3'd0, 8'h00, 4'hF);
         model_step();
         tick();
      end
      chk("rnd_no_loss", n_recv, n_sent);
      chk("rnd_final_vld", {28'b0, out_valid}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
